// File: rtl/fifo_rd_arbiter_pkg.sv
// fifo_rd_arb_pkg: shared types, limits and helpers for the FIFO read-side arbiter.
// Optional feature macro: FIFO_RD_ARB_FIXED_PRIO_EN (fixed lowest-index priority).
package fifo_rd_arb_pkg;

  // Arbiter control states: no owner, or one owner popping words
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_e;

  // Legal parameter ranges; the top refuses to elaborate outside them
  localparam int NREQ_MIN  = 2;
  localparam int NREQ_MAX  = 16;
  localparam int BURST_MIN = 1;

  // True when the consumer count and burst limit are inside the supported range
  function automatic bit params_legal(input int nreq, input int burst);
    return (nreq >= NREQ_MIN) && (nreq <= NREQ_MAX) && (burst >= BURST_MIN);
  endfunction

  // Index of the set bit of a one-hot vector of up to NREQ_MAX bits (0 when empty)
  function automatic logic [3:0] ONEHOT2IDX(input logic [15:0] onehot);
    logic [3:0] idx;
    idx = '0;
    for (int i = 0; i < 16; i++) begin
      if (onehot[i]) begin
        idx = idx | 4'(i);
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/fifo_rd_arbiter_if.sv
// fifo_rd_arbiter_if: bundle between the arbiter, the FIFO read side and the consumers.
// The master modport is the arbiter's view; slave is the surrounding logic.
// Optional feature macro of the block: FIFO_RD_ARB_FIXED_PRIO_EN (no effect here).
interface fifo_rd_arbiter_if
  import fifo_rd_arb_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
);

  logic [NREQ-1:0]  req;
  logic             r_empty;
  logic [WIDTH-1:0] r_data;
  logic             r_inc;
  logic [NREQ-1:0]  gnt;
  logic [WIDTH-1:0] out_data;
  logic [NREQ-1:0]  out_valid;
  logic             busy;

  modport master (
    input  req,
    input  r_empty,
    input  r_data,
    output r_inc,
    output gnt,
    output out_data,
    output out_valid,
    output busy
  );

  modport slave (
    output req,
    output r_empty,
    output r_data,
    input  r_inc,
    input  gnt,
    input  out_data,
    input  out_valid,
    input  busy
  );

endinterface

// File: rtl/fifo_rd_arbiter_rr_pick.sv
// rr_pick: combinational rotate-priority encoder. The search starts one place after
// 'last' and wraps, so the most recent winner has the lowest priority next time.
// Tying 'last' to NREQ-1 turns it into a plain lowest-index-wins encoder, which is
// how the top uses it when FIFO_RD_ARB_FIXED_PRIO_EN is defined.
module rr_pick
  import fifo_rd_arb_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int IDX_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] last,
  output logic [NREQ-1:0]  gnt,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  // Walk the requesters from last+1 around to last and keep the first one found
  always_comb begin
    int cand;
    cand = 0;
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    for (int off = 1; off <= NREQ; off++) begin
      cand = (int'(last) + off) % NREQ;
      if (!any && req[IDX_W'(cand)]) begin
        any                 = 1'b1;
        gnt[IDX_W'(cand)]   = 1'b1;
        idx                 = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/fifo_rd_arbiter.sv
// fifo_rd_arbiter: shares the async FIFO read port among NREQ consumers in the read
// clock domain. One owner at a time pops up to BURST words; each popped word is
// returned one cycle later with a one-hot valid naming its consumer.
// Optional feature macro: FIFO_RD_ARB_FIXED_PRIO_EN -- when defined, the lowest
// requesting index always wins and the round-robin 'last' register is removed.
module fifo_rd_arbiter
  import fifo_rd_arb_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int BURST = 4
) (
  input logic               r_clk,
  input logic               r_rst,
  fifo_rd_arbiter_if.master bus
);

  localparam int IDX_W = $clog2(NREQ);
  localparam int CNT_W = $clog2(BURST) + 1;

  // Refuse to build an arbiter outside the supported consumer/burst range
  if (!params_legal(NREQ, BURST)) begin : g_param_check
    $error("fifo_rd_arbiter: NREQ must be 2..16 and BURST must be >= 1");
  end

  arb_state_e       state_q, state_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic [NREQ-1:0]  out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [IDX_W-1:0] pick_last;
  logic [IDX_W-1:0] pick_idx;
  logic [NREQ-1:0]  pick_gnt;
  logic             pick_any;

  logic [IDX_W-1:0] owner_idx;
  logic             owner_req;
  logic             pop;
  logic             burst_done;
  logic             release_now;

`ifdef FIFO_RD_ARB_FIXED_PRIO_EN
  // Search always starts at index 0, so no winner history is kept
  assign pick_last = IDX_W'(NREQ - 1);
`else
  logic [IDX_W-1:0] last_q, last_d;
  assign pick_last = last_q;
`endif

  rr_pick #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req  (bus.req),
    .last (pick_last),
    .gnt  (pick_gnt),
    .idx  (pick_idx),
    .any  (pick_any)
  );

  // The owner index is recovered from the registered one-hot grant
  assign owner_idx  = IDX_W'(ONEHOT2IDX(16'(gnt_q)));
  assign owner_req  = bus.req[owner_idx];
  assign burst_done = (cnt_q == CNT_W'(BURST - 1));

  // Pop strobe is combinational so a word can move every cycle; reset silences it
  assign pop = (state_q == ST_GRANT) && owner_req && !bus.r_empty && !r_rst;

  // The grant ends on its last allowed pop, or as soon as the owner or the FIFO runs dry
  assign release_now = (pop && burst_done) || !owner_req || bus.r_empty;

  assign bus.r_inc     = pop;
  assign bus.gnt       = gnt_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = (state_q == ST_GRANT);

  // Next-state logic: pick a winner from IDLE, count pops and release while granted
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    out_valid_d = '0;
    out_data_d  = out_data_q;
    cnt_d       = cnt_q;
`ifndef FIFO_RD_ARB_FIXED_PRIO_EN
    last_d      = last_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (pick_any && !bus.r_empty) begin
          state_d = ST_GRANT;
          gnt_d   = pick_gnt;
          cnt_d   = '0;
`ifndef FIFO_RD_ARB_FIXED_PRIO_EN
          last_d  = pick_idx;
`endif
        end
      end
      ST_GRANT: begin
        if (pop) begin
          out_data_d  = bus.r_data;
          out_valid_d = gnt_q;
          cnt_d       = cnt_q + 1'b1;
        end
        if (release_now) begin
          state_d = ST_IDLE;
          gnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  // State and registered outputs; reset drops any in-flight pop and restarts at consumer 0
  always_ff @(posedge r_clk) begin
    if (r_rst) begin
      state_q     <= ST_IDLE;
      gnt_q       <= '0;
      out_valid_q <= '0;
      out_data_q  <= '0;
      cnt_q       <= '0;
`ifndef FIFO_RD_ARB_FIXED_PRIO_EN
      last_q      <= IDX_W'(NREQ - 1);
`endif
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      cnt_q       <= cnt_d;
`ifndef FIFO_RD_ARB_FIXED_PRIO_EN
      last_q      <= last_d;
`endif
    end
  end

`ifdef FIFO_RD_ARB_FIXED_PRIO_EN
  // The encoder's index output only feeds the round-robin history
  logic unused_pick_idx;
  assign unused_pick_idx = ^pick_idx;
`endif

endmodule

// File: tb/tb_fifo_rd_arbiter.sv
// tb_fifo_rd_arbiter: table-driven bench for fifo_rd_arbiter (NREQ=4, WIDTH=8, BURST=4).
// Each row gives one cycle of inputs and the outputs expected during that cycle.
// Popped words go into a scoreboard and are matched against out_data/out_valid.
// Expected grant orders follow FIFO_RD_ARB_FIXED_PRIO_EN when it is defined.
module tb_fifo_rd_arbiter;

  typedef struct {
    logic [3:0] req;
    logic       rst;
    logic       fe;
    logic [3:0] gnt;
    logic       rinc;
    logic [3:0] ov;
    logic       busy;
  } vec_t;

  typedef struct {
    logic [3:0] who;
    logic [7:0] data;
  } sb_t;

`ifdef FIFO_RD_ARB_FIXED_PRIO_EN
  localparam logic [3:0] G_SECOND = 4'b0001;
  localparam logic [3:0] G_THIRD  = 4'b0001;
`else
  localparam logic [3:0] G_SECOND = 4'b0010;
  localparam logic [3:0] G_THIRD  = 4'b1000;
`endif

  logic r_clk;
  logic r_rst;
  logic force_empty;

  vec_t       vecs[$];
  sb_t        sb_q[$];
  logic [7:0] fifo_q[$];

  int n_vec;
  int n_miss;

  fifo_rd_arbiter_if #(.NREQ(4), .WIDTH(8)) bus ();

  fifo_rd_arbiter #(
    .NREQ  (4),
    .WIDTH (8),
    .BURST (4)
  ) dut (
    .r_clk (r_clk),
    .r_rst (r_rst),
    .bus   (bus.master)
  );

  // Free-running read clock, rising edges at 5, 15, 25, ...
  initial begin
    r_clk = 1'b0;
    forever #5 r_clk = ~r_clk;
  end

  function automatic void add(input logic [3:0] req, input logic rst, input logic fe,
                              input logic [3:0] gnt, input logic rinc,
                              input logic [3:0] ov, input logic busy);
    vec_t v;
    v.req  = req;
    v.rst  = rst;
    v.fe   = fe;
    v.gnt  = gnt;
    v.rinc = rinc;
    v.ov   = ov;
    v.busy = busy;
    vecs.push_back(v);
  endfunction

  task automatic checkField(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic refreshFifo();
    bus.r_empty = force_empty || (fifo_q.size() == 0);
    bus.r_data  = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
  endtask

  task automatic loadFifo(input logic [7:0] base, input int n);
    fifo_q.delete();
    for (int i = 0; i < n; i++) begin
      fifo_q.push_back(base + 8'(i));
    end
  endtask

  task automatic resetDut();
    r_rst       = 1'b1;
    bus.req     = 4'b0000;
    force_empty = 1'b0;
    refreshFifo();
    @(posedge r_clk);
    #1;
    sb_q.delete();
  endtask

  task automatic applyStimulus(input vec_t v);
    bus.req     = v.req;
    r_rst       = v.rst;
    force_empty = v.fe;
    refreshFifo();
  endtask

  task automatic checkOutput(input vec_t v, input string tag);
    sb_t e;
    checkField({tag, " gnt"}, 32'(bus.gnt), 32'(v.gnt));
    checkField({tag, " r_inc"}, 32'(bus.r_inc), 32'(v.rinc));
    checkField({tag, " out_valid"}, 32'(bus.out_valid), 32'(v.ov));
    checkField({tag, " busy"}, 32'(bus.busy), 32'(v.busy));
    if (bus.out_valid != 4'b0000) begin
      if (sb_q.size() == 0) begin
        checkField({tag, " unexpected word"}, 32'(bus.out_valid), 32'h0);
      end else begin
        e = sb_q.pop_front();
        checkField({tag, " sb owner"}, 32'(bus.out_valid), 32'(e.who));
        checkField({tag, " sb data"}, 32'(bus.out_data), 32'(e.data));
      end
    end
    if (v.rinc) begin
      e.who  = v.gnt;
      e.data = bus.r_data;
      sb_q.push_back(e);
    end
  endtask

  task automatic runScenario(input string name);
    logic inc;
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      @(negedge r_clk);
      checkOutput(vecs[i], $sformatf("%s[%0d]", name, i));
      inc = bus.r_inc;
      @(posedge r_clk);
      #1;
      if (inc && fifo_q.size() != 0) begin
        void'(fifo_q.pop_front());
      end
    end
    checkField({name, " sb drained"}, 32'(sb_q.size()), 32'h0);
    sb_q.delete();
    vecs.delete();
  endtask

  initial begin
    n_vec  = 0;
    n_miss = 0;

    // Reset held with all requests, then consumer 0 alone: burst of 4, gap, regrant
    resetDut();
    loadFifo(8'h10, 10);
    add(4'hF,1,0, 4'h0,0,4'h0,0);
    add(4'hF,1,0, 4'h0,0,4'h0,0);
    add(4'h1,0,0, 4'h0,0,4'h0,0);
    add(4'h1,0,0, 4'h1,1,4'h0,1);
    add(4'h1,0,0, 4'h1,1,4'h1,1);
    add(4'h1,0,0, 4'h1,1,4'h1,1);
    add(4'h1,0,0, 4'h1,1,4'h1,1);
    add(4'h1,0,0, 4'h0,0,4'h1,0);
    add(4'h1,0,0, 4'h1,1,4'h0,1);
    add(4'h1,0,0, 4'h1,1,4'h1,1);
    add(4'h1,0,0, 4'h1,1,4'h1,1);
    add(4'h1,0,0, 4'h1,1,4'h1,1);
    add(4'h1,0,0, 4'h0,0,4'h1,0);
    add(4'h1,0,0, 4'h1,1,4'h0,1);
    add(4'h1,0,0, 4'h1,1,4'h1,1);
    add(4'h1,0,0, 4'h1,0,4'h1,1);
    add(4'h1,0,0, 4'h0,0,4'h0,0);
    add(4'h1,0,0, 4'h0,0,4'h0,0);
    runScenario("burst");

    // Consumers 0,1,3 requesting: grant order 0,1,3,0 with an idle cycle between
    resetDut();
    loadFifo(8'h20, 16);
    add(4'hB,0,0, 4'h0,0,4'h0,0);
    add(4'hB,0,0, 4'h1,1,4'h0,1);
    add(4'hB,0,0, 4'h1,1,4'h1,1);
    add(4'hB,0,0, 4'h1,1,4'h1,1);
    add(4'hB,0,0, 4'h1,1,4'h1,1);
    add(4'hB,0,0, 4'h0,0,4'h1,0);
    add(4'hB,0,0, G_SECOND,1,4'h0,1);
    add(4'hB,0,0, G_SECOND,1,G_SECOND,1);
    add(4'hB,0,0, G_SECOND,1,G_SECOND,1);
    add(4'hB,0,0, G_SECOND,1,G_SECOND,1);
    add(4'hB,0,0, 4'h0,0,G_SECOND,0);
    add(4'hB,0,0, G_THIRD,1,4'h0,1);
    add(4'hB,0,0, G_THIRD,1,G_THIRD,1);
    add(4'hB,0,0, G_THIRD,1,G_THIRD,1);
    add(4'hB,0,0, G_THIRD,1,G_THIRD,1);
    add(4'hB,0,0, 4'h0,0,G_THIRD,0);
    add(4'hB,0,0, 4'h1,1,4'h0,1);
    add(4'h0,0,0, 4'h1,0,4'h1,1);
    add(4'h0,0,0, 4'h0,0,4'h0,0);
    runScenario("rr");

    // Owner 2 sees the FIFO go empty after two pops
    resetDut();
    loadFifo(8'h30, 8);
    add(4'h4,0,0, 4'h0,0,4'h0,0);
    add(4'h4,0,0, 4'h4,1,4'h0,1);
    add(4'h4,0,0, 4'h4,1,4'h4,1);
    add(4'h4,0,1, 4'h4,0,4'h4,1);
    add(4'h4,0,1, 4'h0,0,4'h0,0);
    add(4'h4,0,0, 4'h0,0,4'h0,0);
    add(4'h4,0,0, 4'h4,1,4'h0,1);
    add(4'h0,0,0, 4'h4,0,4'h4,1);
    add(4'h0,0,0, 4'h0,0,4'h0,0);
    runScenario("empty");

    // Owner 1 drops its request after one pop while consumer 3 waits
    resetDut();
    loadFifo(8'h40, 8);
    add(4'hA,0,0, 4'h0,0,4'h0,0);
    add(4'hA,0,0, 4'h2,1,4'h0,1);
    add(4'h8,0,0, 4'h2,0,4'h2,1);
    add(4'h8,0,0, 4'h0,0,4'h0,0);
    add(4'h8,0,0, 4'h8,1,4'h0,1);
    add(4'h0,0,0, 4'h8,0,4'h8,1);
    add(4'h0,0,0, 4'h0,0,4'h0,0);
    runScenario("drop");

    // Reset during the second pop: that word is never reported, consumer 0 wins next
    resetDut();
    loadFifo(8'h50, 8);
    add(4'h1,0,0, 4'h0,0,4'h0,0);
    add(4'h1,0,0, 4'h1,1,4'h0,1);
    add(4'h1,1,0, 4'h1,0,4'h1,1);
    add(4'h3,0,0, 4'h0,0,4'h0,0);
    add(4'h3,0,0, 4'h1,1,4'h0,1);
    add(4'h2,0,0, 4'h1,0,4'h1,1);
    add(4'h0,0,0, 4'h0,0,4'h0,0);
    runScenario("rst_mid");

    // Requests while empty leave the winner history alone
    resetDut();
    loadFifo(8'h60, 4);
    add(4'h6,0,1, 4'h0,0,4'h0,0);
    add(4'h6,0,1, 4'h0,0,4'h0,0);
    add(4'h6,0,0, 4'h0,0,4'h0,0);
    add(4'h6,0,0, 4'h2,1,4'h0,1);
    add(4'h0,0,0, 4'h2,0,4'h2,1);
    add(4'h0,0,0, 4'h0,0,4'h0,0);
    runScenario("idle_empty");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
